// File: rtl/unlock_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : unlock_hold_timer
// Description : Timed-output driver for the lock datapath. A one-cycle (or
//               level) unlock request releases the bolt for UNLOCK_TIME
//               seconds. If the door opens, the bolt output drops and the
//               door sensor is supervised. If the door stays open longer than
//               DOOR_OPEN_MAX seconds, an alarm is raised and the buzzer is
//               driven with a square wave until the door closes.
//
// Ports       : clk          in   system clock, 1 kHz tick
//               reset        in   asynchronous, active-low reset
//               unlock_req   in   request to release the bolt
//               door_open    in   door sensor, 1 = open (already synchronised)
//               tranca       out  bolt actuator, 1 = released (UNLOCKED only)
//               bip          out  buzzer drive, square wave while alarmed
//               alarm        out  1 while in ALARM
//               relock_pulse out  one-cycle pulse when the unlock window
//                                 expires without the door being opened
//
// Revision    : 1.0 - initial release
// ============================================================================
module unlock_hold_timer #(
    parameter int unsigned UNLOCK_TIME     = 5,
    parameter int unsigned DOOR_OPEN_MAX   = 10,
    parameter int unsigned TICKS_PER_SEC   = 1000,
    parameter int unsigned BEEP_HALF_TICKS = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic unlock_req,
    input  logic door_open,
    output logic tranca,
    output logic bip,
    output logic alarm,
    output logic relock_pulse
);

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_N_UNL  = UNLOCK_TIME * TICKS_PER_SEC;
    localparam int unsigned c_N_OPEN = DOOR_OPEN_MAX * TICKS_PER_SEC;
    localparam int unsigned c_N_MAX  = (c_N_UNL > c_N_OPEN) ? c_N_UNL : c_N_OPEN;

    // One shared counter times both the unlock window and the door-open
    // window. It is cleared on every state entry, so it never wraps.
    localparam int unsigned c_CNT_W  = $clog2(c_N_MAX) + 1;
    localparam int unsigned c_BEEP_W = $clog2(BEEP_HALF_TICKS) + 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_UNL_LAST  = c_CNT_W'(c_N_UNL - 1);
    localparam logic [c_CNT_W-1:0]  c_OPEN_LAST = c_CNT_W'(c_N_OPEN - 1);

    localparam logic [c_BEEP_W-1:0] c_BEEP_ZERO = '0;
    localparam logic [c_BEEP_W-1:0] c_BEEP_ONE  = c_BEEP_W'(1);
    localparam logic [c_BEEP_W-1:0] c_BEEP_LAST = c_BEEP_W'(BEEP_HALF_TICKS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_UNLOCKED = 2'd1;
    localparam logic [1:0] c_ST_OPEN     = 2'd2;
    localparam logic [1:0] c_ST_ALARM    = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and next-value wires
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BEEP_W-1:0] r_beep;
    logic                r_bip;
    logic                r_relock;

    logic [1:0]          w_state_next;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_BEEP_W-1:0] w_beep_next;
    logic                w_bip_next;
    logic                w_relock_next;

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= c_CNT_ZERO;
            r_beep   <= c_BEEP_ZERO;
            r_bip    <= 1'b0;
            r_relock <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_beep   <= w_beep_next;
            r_bip    <= w_bip_next;
            r_relock <= w_relock_next;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and next-datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_beep_next   = r_beep;
        w_bip_next    = r_bip;
        w_relock_next = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // A door opened while idle (forced entry) is not handled here.
                w_cnt_next  = c_CNT_ZERO;
                w_beep_next = c_BEEP_ZERO;
                w_bip_next  = 1'b0;
                if (unlock_req) begin
                    w_state_next = c_ST_UNLOCKED;
                end
            end

            c_ST_UNLOCKED: begin
                w_cnt_next = r_cnt + c_CNT_ONE;
                // Door activity outranks a re-request, which outranks expiry,
                // so a door opening on the last cycle never emits a relock.
                if (door_open) begin
                    w_state_next = c_ST_OPEN;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (unlock_req) begin
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_UNL_LAST) begin
                    w_state_next  = c_ST_IDLE;
                    w_cnt_next    = c_CNT_ZERO;
                    w_relock_next = 1'b1;
                end
            end

            c_ST_OPEN: begin
                w_cnt_next = r_cnt + c_CNT_ONE;
                // Closing the door on the timeout cycle wins over the alarm.
                if (!door_open) begin
                    w_state_next = c_ST_IDLE;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_OPEN_LAST) begin
                    w_state_next = c_ST_ALARM;
                    w_cnt_next   = c_CNT_ZERO;
                    w_beep_next  = c_BEEP_ZERO;
                    w_bip_next   = 1'b1;
                end
            end

            c_ST_ALARM: begin
                w_cnt_next = c_CNT_ZERO;
                if (!door_open) begin
                    w_state_next = c_ST_IDLE;
                    w_beep_next  = c_BEEP_ZERO;
                    w_bip_next   = 1'b0;
                end else if (r_beep == c_BEEP_LAST) begin
                    w_beep_next = c_BEEP_ZERO;
                    w_bip_next  = ~r_bip;
                end else begin
                    w_beep_next = r_beep + c_BEEP_ONE;
                end
            end

            default: begin
                w_state_next = c_ST_IDLE;
                w_cnt_next   = c_CNT_ZERO;
                w_beep_next  = c_BEEP_ZERO;
                w_bip_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs decoded from registered state
    // ------------------------------------------------------------------------
    always_comb begin
        tranca       = (r_state == c_ST_UNLOCKED);
        alarm        = (r_state == c_ST_ALARM);
        bip          = r_bip;
        relock_pulse = r_relock;
    end

endmodule
`default_nettype wire

// File: tb/tb_unlock_hold_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_unlock_hold_timer
// Description : Directed self-checking bench for unlock_hold_timer using
//               TICKS_PER_SEC=10, UNLOCK_TIME=2, DOOR_OPEN_MAX=3,
//               BEEP_HALF_TICKS=5 (N_UNL=20, N_OPEN=30). Outputs are packed
//               as {tranca, bip, alarm, relock_pulse} for each comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unlock_hold_timer;

    logic clk;
    logic reset;
    logic unlock_req;
    logic door_open;
    logic tranca;
    logic bip;
    logic alarm;
    logic relock_pulse;

    int vectors;
    int miscompares;

    unlock_hold_timer #(
        .UNLOCK_TIME     (2),
        .DOOR_OPEN_MAX   (3),
        .TICKS_PER_SEC   (10),
        .BEEP_HALF_TICKS (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .unlock_req   (unlock_req),
        .door_open    (door_open),
        .tranca       (tranca),
        .bip          (bip),
        .alarm        (alarm),
        .relock_pulse (relock_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {tranca, bip, alarm, relock_pulse};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {tranca,bip,alarm,relock}=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        unlock_req  = 1'b0;
        door_open   = 1'b0;

        // ---- 1: reset state, then 50 idle cycles --------------------------
        tick();
        check("rst_hold", 4'b0000);
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("t1_idle%0d", i), 4'b0000);
        end

        // ---- 2: pulse, door closed: 20-cycle window then relock ------------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        check("t2_win0", 4'b1000);
        for (int i = 1; i < 20; i++) begin
            tick();
            check($sformatf("t2_win%0d", i), 4'b1000);
        end
        tick();
        check("t2_relock", 4'b0001);
        tick();
        check("t2_relock_end", 4'b0000);
        tick();
        check("t2_idle", 4'b0000);

        // ---- 3: door opens at cycle 7, closes 12 cycles later --------------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_win%0d", i), 4'b1000);
            tick();
        end
        check("t3_win6", 4'b1000);
        door_open = 1'b1;
        tick();
        check("t3_open", 4'b0000);
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("t3_held%0d", i), 4'b0000);
        end
        door_open = 1'b0;
        tick();
        check("t3_close", 4'b0000);
        // Back in IDLE: an open door must be ignored (no alarm after 30+).
        door_open = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("t3_idle_forced", 4'b0000);
        door_open = 1'b0;
        tick();

        // ---- 4: door held open -> alarm after 30 cycles, bip 5/5 -----------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t4_win3", 4'b1000);
        door_open = 1'b1;
        tick();
        check("t4_open0", 4'b0000);
        for (int i = 1; i < 30; i++) begin
            tick();
            check($sformatf("t4_open%0d", i), 4'b0000);
        end
        tick();
        check("t4_alarm_entry", 4'b0110);
        for (int j = 1; j <= 12; j++) begin
            tick();
            check($sformatf("t4_beep%0d", j), {1'b0, ((j / 5) % 2) == 0, 1'b1, 1'b0});
        end
        door_open = 1'b0;
        tick();
        check("t4_close", 4'b0000);
        tick();
        check("t4_idle", 4'b0000);

        // ---- 5a: door opens at counter=19 -> OPEN, no relock ---------------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("t5a_cnt19", 4'b1000);
        door_open = 1'b1;
        tick();
        check("t5a_open_no_relock", 4'b0000);

        // ---- 5b: door closes at counter=29 in OPEN -> IDLE, no alarm -------
        for (int i = 0; i < 29; i++) tick();
        check("t5b_cnt29", 4'b0000);
        door_open = 1'b0;
        tick();
        check("t5b_close", 4'b0000);
        tick();
        check("t5b_no_alarm", 4'b0000);

        // ---- 5c: re-request at counter=15 restarts the window --------------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("t5c_cnt15", 4'b1000);
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        check("t5c_rewin0", 4'b1000);
        for (int i = 1; i < 20; i++) begin
            tick();
            check($sformatf("t5c_rewin%0d", i), 4'b1000);
        end
        tick();
        check("t5c_relock", 4'b0001);
        tick();
        check("t5c_idle", 4'b0000);

        // ---- 6a: async reset mid-ALARM -------------------------------------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        door_open  = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        check("t6a_alarm", 4'b0110);
        #2 reset = 1'b0;
        #1 check("t6a_async_rst", 4'b0000);
        door_open = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("t6a_after_rst", 4'b0000);

        // ---- 6b: async reset mid-UNLOCKED, then a fresh full window --------
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6b_unlocked", 4'b1000);
        #2 reset = 1'b0;
        #1 check("t6b_async_rst", 4'b0000);
        #1 reset = 1'b1;
        tick();
        check("t6b_after_rst", 4'b0000);
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        check("t6b_win0", 4'b1000);
        for (int i = 1; i < 20; i++) begin
            tick();
            check($sformatf("t6b_win%0d", i), 4'b1000);
        end
        tick();
        check("t6b_relock", 4'b0001);
        tick();
        check("t6b_idle", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/unlock_hold_timer.md
Name: unlock_hold_timer

Overview:
- Timed-output driver for the lock datapath: turns a one-cycle unlock request into a bolt-release output held for a fixed number of seconds.
- Supervises the door sensor while unlocked and raises a buzzer alarm if the door stays open too long.
- Counterpart to the long-press detector: that block measures how long an input is held; this block generates held outputs of measured length.
- Sits between the password/control FSM (source of unlock_req) and the actuator/buzzer pins; clk is the 1 kHz system tick.

Parameters:
- UNLOCK_TIME, 5, seconds the bolt stays released waiting for the door to open.
- DOOR_OPEN_MAX, 10, seconds the door may remain open before the alarm is raised.
- TICKS_PER_SEC, 1000, clk cycles per second.
- BEEP_HALF_TICKS, 250, clk cycles per half-period of the alarm square wave.

Ports:
- clk  in  1  system clock, 1 kHz tick.
- reset  in  1  asynchronous, active-low reset.
- unlock_req  in  1  one-cycle request to release the bolt (level also accepted).
- door_open  in  1  door sensor; 1 = open; already synchronised upstream.
- tranca  out  1  bolt actuator; 1 = released.
- bip  out  1  buzzer drive; square wave while alarmed.
- alarm  out  1  1 while in ALARM state.
- relock_pulse  out  1  one-cycle pulse when the unlock window expires with the door never opened.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0.
  - tranca=0, bip=0, alarm=0, relock_pulse=0.
- Timing constants and widths:
  - N_UNL = UNLOCK_TIME*TICKS_PER_SEC; N_OPEN = DOOR_OPEN_MAX*TICKS_PER_SEC.
  - Single shared counter, width $clog2(max(N_UNL,N_OPEN))+1; it never wraps.
  - Separate beep counter, width $clog2(BEEP_HALF_TICKS)+1.
- Outputs are decoded from registered state, so they change on the same edge as the state transition.
  - tranca=1 only in UNLOCKED.
  - alarm=1 only in ALARM.
  - relock_pulse is a register, high for exactly one cycle.
- IDLE:
  - unlock_req=1 -> UNLOCKED, counter<=0.
  - door_open in IDLE is ignored: a forced door is not this block's concern.
- UNLOCKED:
  - counter increments each cycle.
  - Priority, highest first: door_open=1 -> OPEN, counter<=0; else unlock_req=1 -> stay, counter<=0 (window restarts); else counter==N_UNL-1 -> IDLE with relock_pulse<=1.
  - Result: tranca is high for exactly N_UNL cycles when no door activity and no re-request.
- OPEN (tranca=0; the bolt may re-engage on a latch):
  - counter increments each cycle.
  - door_open=0 -> IDLE. This has priority over timeout on the same cycle.
  - Else counter==N_OPEN-1 -> ALARM, beep counter<=0, bip<=1.
  - unlock_req is ignored.
- ALARM:
  - bip toggles every BEEP_HALF_TICKS cycles, starting high on entry.
  - door_open=0 -> IDLE with bip<=0 on the same edge.
  - unlock_req is ignored.
- Async reset mid-operation in any state returns immediately to reset values; there is no partial timing carry-over.
- The state encoding is a 2-bit enum. Any illegal code recovers to IDLE on the next edge.

Test Plan (TICKS_PER_SEC=10, UNLOCK_TIME=2, DOOR_OPEN_MAX=3, BEEP_HALF_TICKS=5; N_UNL=20, N_OPEN=30):
1. Reset release, no stimulus for 50 cycles -> tranca=0, bip=0, alarm=0, relock_pulse=0 throughout.
2. unlock_req pulse, door stays closed -> tranca=1 for exactly 20 cycles; relock_pulse=1 on the cycle tranca falls, for 1 cycle; state back in IDLE.
3. unlock_req, door_open=1 at cycle 7 -> tranca falls on that edge; door closed 12 cycles later -> IDLE; no alarm, no relock_pulse.
4. unlock_req, door opened at cycle 3 and held -> alarm=1 exactly 30 cycles after opening; bip pattern 5 high/5 low repeating. Close door -> alarm=0 and bip=0 on the same edge.
5. Simultaneous events:
   - In UNLOCKED at counter=19, assert door_open -> OPEN, no relock_pulse.
   - In OPEN at counter=29, deassert door_open -> IDLE, no alarm.
   - unlock_req at counter=15 in UNLOCKED -> tranca stays high 20 further cycles.
6. reset=0 asserted asynchronously mid-ALARM and mid-UNLOCKED -> all outputs 0 before the next clk edge; a fresh unlock_req after release gives a full 20-cycle window.
